// File: rtl/pixie_dma_front_end.sv
// Pixie CPU-side front end: CDP1861 frame/line timing, DMA-out, framebuffer writes.
// Define PIXIE_UNDERRUN_STATUS_EN to add the saturating DMA underrun counter.
module pixie_dma_front_end #(
   parameter int MC_PER_LINE     = 14,
   parameter int LINES_PER_FRAME = 262,
   parameter int START_LINE      = 80,
   parameter int ACTIVE_LINES    = 128,
   parameter int DMA_START_MC    = 2,
   parameter int BYTES_PER_LINE  = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       mc_strobe,
   input  logic       disp_on,
   input  logic       disp_off,
   input  logic       dma_ack,
   input  logic [7:0] data_in,
`ifdef PIXIE_UNDERRUN_STATUS_EN
   input  logic       underrun_clr,
   output logic [7:0] underrun_cnt,
`endif
   output logic       dma_req,
   output logic       int_req,
   output logic       efx,
   output logic       fb_we,
   output logic [9:0] fb_addr,
   output logic [7:0] fb_wdata,
   output logic       frame_start
);

   localparam logic [1:0] S_OFF   = 2'd0;
   localparam logic [1:0] S_BLANK = 2'd1;
   localparam logic [1:0] S_DMA   = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [3:0] MC_LAST  = 4'(MC_PER_LINE - 1);
   localparam logic [3:0] MC_PRE   = 4'(DMA_START_MC - 1);
   localparam logic [8:0] LN_LAST  = 9'(LINES_PER_FRAME - 1);
   localparam logic [8:0] LN_START = 9'(START_LINE);
   localparam logic [8:0] LN_END   = 9'(START_LINE + ACTIVE_LINES);
   localparam logic [8:0] LN_INT   = 9'(START_LINE - 2);
   localparam logic [8:0] LN_EF0   = 9'(START_LINE - 4);
   localparam logic [8:0] LN_EF1   = 9'(START_LINE + ACTIVE_LINES - 4);
   localparam logic [2:0] CNT_LAST = 3'(BYTES_PER_LINE - 1);

   logic [3:0] mc_q, mc_d;
   logic [8:0] line_q, line_d;
   logic       en_q, en_d;
   logic [1:0] state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic       we_q, we_d;
   logic [9:0] addr_q, addr_d;
   logic [7:0] wdata_q, wdata_d;
   logic       fs_q, fs_d;
   logic       line_end, xfer, active;
   logic [6:0] line_idx;

   assign line_end = mc_strobe && (mc_q == MC_LAST);
   assign xfer     = (state_q == S_DMA) && mc_strobe && dma_ack;
   assign active   = en_q && (line_q >= LN_START) && (line_q < LN_END);
   assign line_idx = 7'(line_q - LN_START);

   always_comb begin
      mc_d   = mc_q;
      line_d = line_q;
      if (mc_strobe) begin
         if (mc_q == MC_LAST) begin
            mc_d   = 4'd0;
            line_d = (line_q == LN_LAST) ? 9'd0 : line_q + 9'd1;
         end else begin
            mc_d = mc_q + 4'd1;
         end
      end
      fs_d = line_end && (line_q == LN_LAST);
      // off wins over a same-cycle on
      en_d = disp_off ? 1'b0 : (disp_on ? 1'b1 : en_q);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_OFF: if (en_q) state_d = S_BLANK;
         S_BLANK: begin
            if (mc_strobe && (mc_q == MC_PRE) && active) begin
               state_d = S_DMA;
               cnt_d   = 3'd0;
            end
         end
         S_DMA: begin
            if (xfer) begin
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == CNT_LAST) state_d = S_DONE;
            end
            // line end abandons any bytes still owed
            if (line_end) begin
               state_d = S_BLANK;
               cnt_d   = 3'd0;
            end
         end
         default: if (line_end) state_d = S_BLANK;
      endcase
      if (disp_off) state_d = S_OFF;
   end

   always_comb begin
      we_d    = xfer;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      if (xfer) begin
         addr_d  = {line_idx, cnt_q};
         wdata_d = data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         mc_q    <= 4'd0;
         line_q  <= 9'd0;
         en_q    <= 1'b0;
         state_q <= S_OFF;
         cnt_q   <= 3'd0;
         we_q    <= 1'b0;
         addr_q  <= 10'd0;
         wdata_q <= 8'd0;
         fs_q    <= 1'b0;
      end else begin
         mc_q    <= mc_d;
         line_q  <= line_d;
         en_q    <= en_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         fs_q    <= fs_d;
      end
   end

`ifdef PIXIE_UNDERRUN_STATUS_EN
   logic [7:0] ur_q, ur_d;
   logic       underrun;

   assign underrun = (state_q == S_DMA) && line_end &&
                     !(xfer && (cnt_q == CNT_LAST));

   always_comb begin
      ur_d = ur_q;
      if (underrun_clr)                   ur_d = 8'd0;
      else if (underrun && ur_q != 8'hFF) ur_d = ur_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) ur_q <= 8'd0;
      else          ur_q <= ur_d;
   end

   assign underrun_cnt = ur_q;
`endif

   assign dma_req     = (state_q == S_DMA);
   assign int_req     = en_q && (line_q >= LN_INT) && (line_q < LN_START);
   assign efx         = en_q && (((line_q >= LN_EF0) && (line_q < LN_START)) ||
                                 ((line_q >= LN_EF1) && (line_q < LN_END)));
   assign fb_we       = we_q;
   assign fb_addr     = addr_q;
   assign fb_wdata    = wdata_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_pixie_dma_front_end.sv
// Directed bench for pixie_dma_front_end: timing, flags, DMA writes,
// underrun, display off and reset-mid-transfer.
module tb_pixie_dma_front_end;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       mc_strobe = 1'b0;
   logic       disp_on = 1'b0;
   logic       disp_off = 1'b0;
   logic       dma_ack = 1'b0;
   logic [7:0] data_in = 8'd0;
   logic       dma_req, int_req, efx, fb_we, frame_start;
   logic [9:0] fb_addr;
   logic [7:0] fb_wdata;
`ifdef PIXIE_UNDERRUN_STATUS_EN
   logic       underrun_clr = 1'b0;
   logic [7:0] underrun_cnt;
`endif

   int errors = 0;
   int checks = 0;
   int line_b = 0;
   int mc_b = 0;
   int mode = 0;
   int fs_cnt = 0;
   bit any_flag = 1'b0;
   bit dreq_seen = 1'b0;
   bit trk80 = 1'b0;
   bit int_line[262];
   bit efx_line[262];
   bit dreq80[14];
   logic [9:0] wa[$];
   logic [7:0] wd[$];

   pixie_dma_front_end dut (
      .clk(clk),
      .reset_n(reset_n),
      .mc_strobe(mc_strobe),
      .disp_on(disp_on),
      .disp_off(disp_off),
      .dma_ack(dma_ack),
      .data_in(data_in),
`ifdef PIXIE_UNDERRUN_STATUS_EN
      .underrun_clr(underrun_clr),
      .underrun_cnt(underrun_cnt),
`endif
      .dma_req(dma_req),
      .int_req(int_req),
      .efx(efx),
      .fb_we(fb_we),
      .fb_addr(fb_addr),
      .fb_wdata(fb_wdata),
      .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic observe();
      if (fb_we) begin
         wa.push_back(fb_addr);
         wd.push_back(fb_wdata);
      end
      if (int_req) int_line[line_b] = 1'b1;
      if (efx) efx_line[line_b] = 1'b1;
      if (frame_start) fs_cnt++;
      if (dma_req) dreq_seen = 1'b1;
      any_flag |= dma_req | int_req | efx | fb_we;
   endtask

   task automatic strobe1();
      mc_strobe = 1'b1;
      dma_ack   = (mode == 1) || (mode == 2 && !(line_b == 81 && mc_b >= 7));
      data_in   = 8'(160 + mc_b - 2);
      step();
      if (mc_b == 13) begin
         mc_b   = 0;
         line_b = (line_b == 261) ? 0 : line_b + 1;
      end else begin
         mc_b++;
      end
      if (trk80 && line_b == 80) dreq80[mc_b] = dma_req;
      observe();
      mc_strobe = 1'b0;
      dma_ack   = 1'b0;
      step();
      observe();
   endtask

   task automatic run_n(input int n);
      for (int i = 0; i < n; i++) strobe1();
   endtask

   task automatic pulse_on();
      disp_on = 1'b1;
      step();
      disp_on = 1'b0;
      step();
   endtask

   task automatic clear_obs();
      foreach (int_line[i]) int_line[i] = 1'b0;
      foreach (efx_line[i]) efx_line[i] = 1'b0;
      wa.delete();
      wd.delete();
      fs_cnt    = 0;
      any_flag  = 1'b0;
      dreq_seen = 1'b0;
   endtask

   initial begin
      repeat (3) step();
      chk("rst_dma_req", dma_req, 0);
      chk("rst_int_req", int_req, 0);
      chk("rst_efx", efx, 0);
      chk("rst_fb_we", fb_we, 0);
      chk("rst_fb_addr", fb_addr, 0);
      chk("rst_frame_start", frame_start, 0);
      reset_n = 1'b1;
      step();

      // display never enabled: one full frame
      clear_obs();
      run_n(3668);
      chk("off_flags", any_flag, 0);
      chk("off_frame_start_cnt", fs_cnt, 1);

      // full displayed frame, ack every strobe
      pulse_on();
      clear_obs();
      mode  = 1;
      trk80 = 1'b1;
      run_n(3668);
      trk80 = 1'b0;
      chk("a_fs_cnt", fs_cnt, 1);
      chk("a_int_77", int_line[77], 0);
      chk("a_int_78", int_line[78], 1);
      chk("a_int_79", int_line[79], 1);
      chk("a_int_80", int_line[80], 0);
      chk("a_efx_75", efx_line[75], 0);
      chk("a_efx_76", efx_line[76], 1);
      chk("a_efx_79", efx_line[79], 1);
      chk("a_efx_204", efx_line[204], 1);
      chk("a_efx_207", efx_line[207], 1);
      chk("a_efx_208", efx_line[208], 0);
      chk("a_dreq80_mc1", dreq80[1], 0);
      chk("a_dreq80_mc2", dreq80[2], 1);
      chk("a_dreq80_mc9", dreq80[9], 1);
      chk("a_dreq80_mc10", dreq80[10], 0);
      chk("a_wr_count", wa.size(), 1024);
      chk("a_w0_addr", wa[0], 10'h000);
      chk("a_w0_data", wd[0], 8'hA0);
      chk("a_w7_addr", wa[7], 10'h007);
      chk("a_w7_data", wd[7], 8'hA7);
      chk("a_w1016_addr", wa[1016], 10'h3F8);
      chk("a_w1023_addr", wa[1023], 10'h3FF);
      chk("a_w1023_data", wd[1023], 8'hA7);

      // underrun on line 81, then disp_off mid line 90
      clear_obs();
      mode = 2;
      run_n(1265);
      chk("b_dreq_before_off", dma_req, 1);
      chk("b_wr_count", wa.size(), 80);
      chk("b_w8_addr", wa[8], 10'h008);
      chk("b_w12_addr", wa[12], 10'h00C);
      chk("b_w12_data", wd[12], 8'hA4);
      chk("b_w13_addr", wa[13], 10'h010);
      chk("b_w13_data", wd[13], 8'hA0);
      chk("b_w79_addr", wa[79], 10'h052);
      disp_off = 1'b1;
      step();
      disp_off = 1'b0;
      chk("b_dreq_after_off", dma_req, 0);
      dreq_seen = 1'b0;
      mode = 1;
      run_n(20);
      chk("b_off_no_dreq", dreq_seen, 0);
      chk("b_off_wr_count", wa.size(), 80);
      disp_on  = 1'b1;
      disp_off = 1'b1;
      step();
      disp_on  = 1'b0;
      disp_off = 1'b0;
      step();
      any_flag = 1'b0;
      run_n(28);
      chk("b_onoff_flags", any_flag, 0);
      chk("b_onoff_wr_count", wa.size(), 80);
`ifdef PIXIE_UNDERRUN_STATUS_EN
      chk("ur_cnt", underrun_cnt, 1);
      underrun_clr = 1'b1;
      step();
      underrun_clr = 1'b0;
      chk("ur_cnt_clr", underrun_cnt, 0);
`endif

      // reset during a DMA write cycle on line 94
      pulse_on();
      run_n(7);
      chk("r_dreq_pre", dma_req, 1);
      mc_strobe = 1'b1;
      dma_ack   = 1'b1;
      data_in   = 8'h5A;
      reset_n   = 1'b0;
      step();
      mc_strobe = 1'b0;
      dma_ack   = 1'b0;
      chk("r_fb_we", fb_we, 0);
      chk("r_dma_req", dma_req, 0);
      chk("r_fb_addr", fb_addr, 0);
      chk("r_fb_wdata", fb_wdata, 0);
      chk("r_int_efx", {int_req, efx, frame_start}, 0);
      reset_n = 1'b1;
      step();
      chk("r_fb_we_after", fb_we, 0);
      line_b = 0;
      mc_b   = 0;
      mode   = 0;
      pulse_on();
      run_n(1091);
      chk("r_int_l77", int_req, 0);
      chk("r_efx_l77", efx, 1);
      run_n(1);
      chk("r_int_l78", int_req, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pixie_dma_front_end.md
Name: pixie_dma_front_end

Overview:
- CPU-side stage of the Pixie video pipeline, upstream of the display back end. It owns the shared 1024-byte framebuffer write port.
- Tracks CDP1861-style frame/line timing in CPU machine cycles and raises INT and EF flags for the CDP1802.
- Issues DMA-out requests on active lines and writes each DMA byte into the dual-port framebuffer (8 bytes/line, 128 lines). The back end reads the same framebuffer.

Parameters:
- MC_PER_LINE, 14, machine cycles per scan line (14 x 8 clocks = 112 pixel clocks)
- LINES_PER_FRAME, 262, lines per frame
- START_LINE, 80, first active display line
- ACTIVE_LINES, 128, number of active lines
- DMA_START_MC, 2, machine cycle in which dma_req first asserts on an active line
- BYTES_PER_LINE, 8, DMA transfers per active line

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- mc_strobe  in  1  one-clk pulse per CPU machine cycle; all timing advances only on it
- disp_on  in  1  one-clk pulse: display enable (CPU INP 1 decode)
- disp_off  in  1  one-clk pulse: display disable (CPU OUT 1 decode)
- dma_ack  in  1  CPU is in a DMA-out cycle; qualified by mc_strobe
- data_in  in  8  CPU data bus during DMA-out
- dma_req  out  1  DMA-out request to CPU
- int_req  out  1  interrupt request to CPU
- efx  out  1  EF1 flag to CPU
- fb_we  out  1  framebuffer write strobe
- fb_addr  out  10  framebuffer write address {line[6:0], byte[2:0]}
- fb_wdata  out  8  framebuffer write data
- frame_start  out  1  one-clk pulse at line 0, mc 0

Behaviour:
- Reset: all outputs 0. Counters mc=0, line=0. display_en=0. FSM=OFF.
- Counters: on mc_strobe, mc increments. At MC_PER_LINE-1, mc wraps to 0 and line increments. line wraps LINES_PER_FRAME-1 -> 0. With no mc_strobe, counters, requests and flags hold.
- display_en: set by disp_on, cleared by disp_off. Both in the same clk: off wins. Takes effect the next clk.
- Active line: display_en=1 and START_LINE <= line < START_LINE+ACTIVE_LINES. line_idx = line-START_LINE, 7 bits.
- int_req: 1 while display_en and line in [START_LINE-2, START_LINE-1]. Cleared at the START_LINE mc0 strobe, or on disp_off.
- efx: 1 while display_en and line is in [START_LINE-4, START_LINE-1] or [START_LINE+ACTIVE_LINES-4, START_LINE+ACTIVE_LINES-1].
- FSM states:
  - OFF: display_en=0.
  - BLANK: non-active line, or mc < DMA_START_MC.
  - DMA: dma_req=1.
  - DONE: 8 bytes transferred, waiting for the line end.
- Transitions:
  - OFF->BLANK on display_en.
  - BLANK->DMA at the mc_strobe where mc becomes DMA_START_MC on an active line. byte_cnt clears to 0 on entry.
  - DMA->DONE after the BYTES_PER_LINE-th acked transfer.
  - DMA or DONE->BLANK on line wrap.
  - any->OFF on disp_off.
- Transfer: in DMA, a clk with mc_strobe & dma_ack & dma_req writes one byte. Next clk: fb_we=1 for 1 clk, fb_addr={line_idx, byte_cnt}, fb_wdata=data_in captured. byte_cnt then increments, 3-bit.
  - dma_req drops in the same clk the 8th write is registered.
- dma_ack outside DMA state, or without mc_strobe: ignored, no write.
- Line end reached in DMA with fewer than 8 acks: requests abandoned, byte_cnt reset, no write for the missing bytes (underrun).
- disp_off mid-DMA: dma_req=0 next clk. A write already captured still completes.
- frame_start: pulses 1 clk after the mc_strobe that makes line=0, mc=0, regardless of display_en.
- reset_n low mid-transfer: pending write is discarded and fb_we stays 0.

Optional Feature:
- Macro PIXIE_UNDERRUN_STATUS_EN.
- When defined:
  - adds output underrun_cnt[7:0]: saturating count (stops at 255) of active lines ended with fewer than 8 acks.
  - adds input underrun_clr: clears the count to 0; clear wins over a same-clk increment.
  - reset value 0.
- When undefined: ports are absent and no counter logic is built.

Test Plan:
- Reset, then 262x14 mc_strobes with no disp_on -> dma_req, int_req, efx, fb_we stay 0. frame_start pulses once per 3668 strobes.
- disp_on, ack every strobe -> int_req high on lines 78-79. On line 80, 8 writes at fb_addr 0x000-0x007 with data_in 0xA0..0xA7. dma_req low from mc 10.
- Frame with acks -> line 207 writes 0x3F8-0x3FF. efx high on lines 76-79 and 204-207, low on line 208.
- Only 5 acks on line 81 -> writes 0x008-0x00C only. Line 82 restarts at 0x010. With macro defined, underrun_cnt=1.
- disp_off asserted mid-line 90 after 3 acks -> dma_req low next clk, 3 writes only, FSM OFF. disp_on and disp_off in the same clk -> stays OFF.
- reset_n low for 1 clk during a DMA write cycle -> no fb_we pulse, all outputs 0, counters at line 0, mc 0.
